// File: rtl/mips_pkg.sv
// mips_pkg: shared definitions for the MIPS integer pipeline.
//   - DW_DEFAULT / RW_DEFAULT : default datapath and register-index widths
//   - alu_func_e              : ALU function codes driven on alu_function
//   - ctrl_t                  : control bundle carried from ID through EX
package mips_pkg;

  localparam int DW_DEFAULT = 32;
  localparam int RW_DEFAULT = 5;

  typedef enum logic [3:0] {
    ALU_ADD = 4'b0000,
    ALU_SUB = 4'b0010,
    ALU_AND = 4'b0100,
    ALU_OR  = 4'b0101,
    ALU_NOR = 4'b0110,
    ALU_XOR = 4'b0111,
    ALU_SL  = 4'b1000,
    ALU_SRA = 4'b1001,
    ALU_SRL = 4'b1010
  } alu_func_e;

  typedef struct packed {
    logic wb_en;
    logic mem_read;
    logic mem_write;
  } ctrl_t;

  localparam ctrl_t CTRL_NONE = '0;

  function automatic ctrl_t ctrl_pack(input logic wb_en, input logic mem_read,
                                      input logic mem_write);
    ctrl_t c;
    c.wb_en     = wb_en;
    c.mem_read  = mem_read;
    c.mem_write = mem_write;
    return c;
  endfunction

endpackage

// File: rtl/id_ex_stage_if.sv
// id_ex_if: all non-clock signals around the ID/EX stage.
//   master : the surrounding pipeline (ID stage, hazard control, EX/MEM and
//            MEM/WB forward sources); drives ID data, stall/flush, forwards.
//   slave  : the id_ex_stage itself; drives ALU operands, EX control and
//            the load-use stall request.
interface id_ex_if #(
  parameter int DW = 32,
  parameter int RW = 5
);

  // ID side
  logic          id_valid;
  logic [DW-1:0] id_pc;
  logic [DW-1:0] id_rs_val;
  logic [DW-1:0] id_rt_val;
  logic [DW-1:0] id_imm;
  logic [RW-1:0] id_rs_idx;
  logic [RW-1:0] id_rt_idx;
  logic [RW-1:0] id_dest;
  logic [3:0]    id_func;
  logic          id_use_imm;
  logic          id_wb_en;
  logic          id_mem_read;
  logic          id_mem_write;

  // pipeline control
  logic          stall;
  logic          flush;

  // forward sources
  logic          mem_fwd_en;
  logic [RW-1:0] mem_fwd_dest;
  logic [DW-1:0] mem_fwd_data;
  logic          wb_fwd_en;
  logic [RW-1:0] wb_fwd_dest;
  logic [DW-1:0] wb_fwd_data;

  // EX side
  logic          load_use_stall;
  logic          ex_valid;
  logic [DW-1:0] ex_pc;
  logic [DW-1:0] alu_dataa;
  logic [DW-1:0] alu_datab;
  logic [3:0]    alu_function;
  logic [DW-1:0] ex_store_data;
  logic [RW-1:0] ex_dest;
  logic          ex_wb_en;
  logic          ex_mem_read;
  logic          ex_mem_write;

  modport master (
    output id_valid, id_pc, id_rs_val, id_rt_val, id_imm, id_rs_idx, id_rt_idx,
           id_dest, id_func, id_use_imm, id_wb_en, id_mem_read, id_mem_write,
           stall, flush,
           mem_fwd_en, mem_fwd_dest, mem_fwd_data,
           wb_fwd_en, wb_fwd_dest, wb_fwd_data,
    input  load_use_stall, ex_valid, ex_pc, alu_dataa, alu_datab, alu_function,
           ex_store_data, ex_dest, ex_wb_en, ex_mem_read, ex_mem_write
  );

  modport slave (
    input  id_valid, id_pc, id_rs_val, id_rt_val, id_imm, id_rs_idx, id_rt_idx,
           id_dest, id_func, id_use_imm, id_wb_en, id_mem_read, id_mem_write,
           stall, flush,
           mem_fwd_en, mem_fwd_dest, mem_fwd_data,
           wb_fwd_en, wb_fwd_dest, wb_fwd_data,
    output load_use_stall, ex_valid, ex_pc, alu_dataa, alu_datab, alu_function,
           ex_store_data, ex_dest, ex_wb_en, ex_mem_read, ex_mem_write
  );

endinterface

// File: rtl/id_ex_stage_fwd_mux.sv
// fwd_mux: per-operand forwarding select.
//   reg_idx/reg_val           : operand index and value held in ID/EX
//   mem_en/mem_dest/mem_data  : EX/MEM producer
//   wb_en/wb_dest/wb_data     : MEM/WB producer
//   operand                   : resolved operand value
// EX/MEM is younger than MEM/WB, so it wins when both match. r0 is
// hard-wired zero and is never forwarded.
module fwd_mux #(
  parameter int DW = 32,
  parameter int RW = 5
) (
  input  logic [RW-1:0] reg_idx,
  input  logic [DW-1:0] reg_val,
  input  logic          mem_en,
  input  logic [RW-1:0] mem_dest,
  input  logic [DW-1:0] mem_data,
  input  logic          wb_en,
  input  logic [RW-1:0] wb_dest,
  input  logic [DW-1:0] wb_data,
  output logic [DW-1:0] operand
);

  logic mem_hit;
  logic wb_hit;

  assign mem_hit = mem_en && (mem_dest != '0) && (mem_dest == reg_idx);
  assign wb_hit  = wb_en  && (wb_dest  != '0) && (wb_dest  == reg_idx);

  always_comb begin
    operand = reg_val;
    if (mem_hit) begin
      operand = mem_data;
    end else if (wb_hit) begin
      operand = wb_data;
    end
  end

endmodule

// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register and ALU operand select.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : id_ex_if slave port (ID inputs, stall/flush, EX/MEM and
//              MEM/WB forward sources in; ALU operands, EX control and
//              load_use_stall out)
// Holds one decoded instruction for its EX cycle, forwards operands from
// EX/MEM and MEM/WB, and bubbles EX when ID depends on a load in EX.
module id_ex_stage
  import mips_pkg::*;
#(
  parameter int DW = DW_DEFAULT,
  parameter int RW = RW_DEFAULT
) (
  input  logic   clk,
  input  logic   rst,
  id_ex_if.slave bus
);

  logic          r_valid;
  logic [DW-1:0] r_pc;
  logic [DW-1:0] r_rs_val;
  logic [DW-1:0] r_rt_val;
  logic [DW-1:0] r_imm;
  logic [RW-1:0] r_rs_idx;
  logic [RW-1:0] r_rt_idx;
  logic [RW-1:0] r_dest;
  logic [3:0]    r_func;
  logic          r_use_imm;
  ctrl_t         r_ctrl;

  logic          load_use;
  logic          wb_live;
  logic          cap_rs_hit;
  logic          cap_rt_hit;
  logic          hold_rs_hit;
  logic          hold_rt_hit;
  logic [DW-1:0] fwd_rs;
  logic [DW-1:0] fwd_rt;

  assign load_use = r_valid && r_ctrl.mem_read && (r_dest != '0) && bus.id_valid &&
                    ((bus.id_rs_idx == r_dest) || (bus.id_rt_idx == r_dest));

  // MEM/WB retires in the same edge we sample, so the register file read in
  // ID (or the value held in EX) may be stale; take the retiring data instead.
  assign wb_live     = bus.wb_fwd_en && (bus.wb_fwd_dest != '0);
  assign cap_rs_hit  = wb_live && (bus.wb_fwd_dest == bus.id_rs_idx);
  assign cap_rt_hit  = wb_live && (bus.wb_fwd_dest == bus.id_rt_idx);
  assign hold_rs_hit = wb_live && (bus.wb_fwd_dest == r_rs_idx);
  assign hold_rt_hit = wb_live && (bus.wb_fwd_dest == r_rt_idx);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid   <= 1'b0;
      r_pc      <= '0;
      r_rs_val  <= '0;
      r_rt_val  <= '0;
      r_imm     <= '0;
      r_rs_idx  <= '0;
      r_rt_idx  <= '0;
      r_dest    <= '0;
      r_func    <= ALU_ADD;
      r_use_imm <= 1'b0;
      r_ctrl    <= CTRL_NONE;
    end else if (bus.flush) begin
      r_valid <= 1'b0;
      r_ctrl  <= CTRL_NONE;
    end else if (bus.stall) begin
      if (hold_rs_hit) begin
        r_rs_val <= bus.wb_fwd_data;
      end
      if (hold_rt_hit) begin
        r_rt_val <= bus.wb_fwd_data;
      end
    end else if (load_use) begin
      r_valid <= 1'b0;
      r_ctrl  <= CTRL_NONE;
    end else begin
      r_valid   <= bus.id_valid;
      r_pc      <= bus.id_pc;
      r_rs_val  <= cap_rs_hit ? bus.wb_fwd_data : bus.id_rs_val;
      r_rt_val  <= cap_rt_hit ? bus.wb_fwd_data : bus.id_rt_val;
      r_imm     <= bus.id_imm;
      r_rs_idx  <= bus.id_rs_idx;
      r_rt_idx  <= bus.id_rt_idx;
      r_dest    <= bus.id_dest;
      r_func    <= bus.id_func;
      r_use_imm <= bus.id_use_imm;
      r_ctrl    <= ctrl_pack(bus.id_wb_en, bus.id_mem_read, bus.id_mem_write);
    end
  end

  fwd_mux #(.DW(DW), .RW(RW)) u_fwd_rs (
    .reg_idx  (r_rs_idx),
    .reg_val  (r_rs_val),
    .mem_en   (bus.mem_fwd_en),
    .mem_dest (bus.mem_fwd_dest),
    .mem_data (bus.mem_fwd_data),
    .wb_en    (bus.wb_fwd_en),
    .wb_dest  (bus.wb_fwd_dest),
    .wb_data  (bus.wb_fwd_data),
    .operand  (fwd_rs)
  );

  fwd_mux #(.DW(DW), .RW(RW)) u_fwd_rt (
    .reg_idx  (r_rt_idx),
    .reg_val  (r_rt_val),
    .mem_en   (bus.mem_fwd_en),
    .mem_dest (bus.mem_fwd_dest),
    .mem_data (bus.mem_fwd_data),
    .wb_en    (bus.wb_fwd_en),
    .wb_dest  (bus.wb_fwd_dest),
    .wb_data  (bus.wb_fwd_data),
    .operand  (fwd_rt)
  );

  assign bus.load_use_stall = load_use;
  assign bus.ex_valid       = r_valid;
  assign bus.ex_pc          = r_pc;
  assign bus.alu_dataa      = fwd_rs;
  assign bus.alu_datab      = r_use_imm ? r_imm : fwd_rt;
  assign bus.alu_function   = r_func;
  assign bus.ex_store_data  = fwd_rt;
  assign bus.ex_dest        = r_dest;
  assign bus.ex_wb_en       = r_valid & r_ctrl.wb_en;
  assign bus.ex_mem_read    = r_valid & r_ctrl.mem_read;
  assign bus.ex_mem_write   = r_valid & r_ctrl.mem_write;

endmodule

// File: tb/tb_id_ex_stage.sv
module tb_id_ex_stage;

  typedef struct {
    bit valid; logic [31:0] pc, rs_val, rt_val, imm;
    logic [4:0] rs, rt, dest; logic [3:0] func;
    bit use_imm, wb_en, mem_read, mem_write, stall, flush;
    bit mfe; logic [4:0] mfd; logic [31:0] mfdata;
    bit wfe; logic [4:0] wfd; logic [31:0] wfdata;
  } stim_t;

  typedef struct {
    bit valid; logic [31:0] pc, rs_val, rt_val, imm;
    logic [4:0] rs, rt, dest; logic [3:0] func;
    bit use_imm, wb_en, mem_read, mem_write;
  } ex_t;

  typedef struct {
    bit lus, valid; logic [31:0] pc, a, b, store;
    logic [3:0] func; logic [4:0] dest; bit wb, mr, mw;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  id_ex_if #(.DW(32), .RW(5)) bus ();
  id_ex_stage #(.DW(32), .RW(5)) dut (.clk(clk), .rst(rst), .bus(bus));

  int   n_tests = 0;
  int   n_fail  = 0;
  bit   sb_on   = 0;
  exp_t sb_q[$];
  ex_t  ex;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic stim_t idle();
    stim_t s;
    s = '{default: '0};
    return s;
  endfunction

  // Most recent producer first; r0 never forwards.
  function automatic logic [31:0] resolve(input logic [4:0] idx, input logic [31:0] held,
                                          input stim_t s);
    bit          en[2];
    logic [4:0]  dst[2];
    logic [31:0] dat[2];
    en[0] = s.mfe; dst[0] = s.mfd; dat[0] = s.mfdata;
    en[1] = s.wfe; dst[1] = s.wfd; dat[1] = s.wfdata;
    for (int k = 0; k < 2; k++)
      if (en[k] && dst[k] != 0 && dst[k] == idx) return dat[k];
    return held;
  endfunction

  function automatic bit model_lus(input ex_t e, input stim_t s);
    return e.valid && e.mem_read && e.dest != 0 && s.valid &&
           (s.rs == e.dest || s.rt == e.dest);
  endfunction

  function automatic bit wb_retires(input stim_t s, input logic [4:0] idx);
    return s.wfe && s.wfd != 0 && s.wfd == idx;
  endfunction

  function automatic ex_t model_next(input ex_t e, input stim_t s);
    ex_t n = e;
    if (s.flush || (!s.stall && model_lus(e, s))) begin
      n.valid = 0; n.wb_en = 0; n.mem_read = 0; n.mem_write = 0;
    end else if (s.stall) begin
      if (wb_retires(s, e.rs)) n.rs_val = s.wfdata;
      if (wb_retires(s, e.rt)) n.rt_val = s.wfdata;
    end else begin
      n.valid = s.valid; n.pc = s.pc; n.imm = s.imm;
      n.rs = s.rs; n.rt = s.rt; n.dest = s.dest; n.func = s.func;
      n.use_imm = s.use_imm; n.wb_en = s.wb_en;
      n.mem_read = s.mem_read; n.mem_write = s.mem_write;
      n.rs_val = wb_retires(s, s.rs) ? s.wfdata : s.rs_val;
      n.rt_val = wb_retires(s, s.rt) ? s.wfdata : s.rt_val;
    end
    return n;
  endfunction

  task automatic apply(input stim_t s);
    bus.id_valid = s.valid;   bus.id_pc = s.pc;
    bus.id_rs_val = s.rs_val; bus.id_rt_val = s.rt_val; bus.id_imm = s.imm;
    bus.id_rs_idx = s.rs;     bus.id_rt_idx = s.rt;     bus.id_dest = s.dest;
    bus.id_func = s.func;     bus.id_use_imm = s.use_imm;
    bus.id_wb_en = s.wb_en;   bus.id_mem_read = s.mem_read; bus.id_mem_write = s.mem_write;
    bus.stall = s.stall;      bus.flush = s.flush;
    bus.mem_fwd_en = s.mfe;   bus.mem_fwd_dest = s.mfd; bus.mem_fwd_data = s.mfdata;
    bus.wb_fwd_en = s.wfe;    bus.wb_fwd_dest = s.wfd;  bus.wb_fwd_data = s.wfdata;
  endtask

  // Present one cycle of stimulus, queue what EX must show during it,
  // then advance the model across the edge.
  task automatic drive_cycle(input stim_t s);
    exp_t        e;
    logic [31:0] rt_f;
    apply(s);
    rt_f    = resolve(ex.rt, ex.rt_val, s);
    e.lus   = model_lus(ex, s);
    e.valid = ex.valid;
    e.pc    = ex.pc;
    e.a     = resolve(ex.rs, ex.rs_val, s);
    e.b     = ex.use_imm ? ex.imm : rt_f;
    e.store = rt_f;
    e.func  = ex.func;
    e.dest  = ex.dest;
    e.wb    = ex.valid && ex.wb_en;
    e.mr    = ex.valid && ex.mem_read;
    e.mw    = ex.valid && ex.mem_write;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    ex = model_next(ex, s);
  endtask

  function automatic stim_t rand_stim();
    stim_t s;
    s = idle();
    s.valid     = ($urandom_range(0, 99) < 80);
    s.pc        = $urandom;
    s.rs_val    = $urandom;
    s.rt_val    = $urandom;
    s.imm       = $urandom;
    s.rs        = 5'($urandom_range(0, 3));
    s.rt        = 5'($urandom_range(0, 3));
    s.dest      = 5'($urandom_range(0, 3));
    s.func      = 4'($urandom_range(0, 15));
    s.use_imm   = ($urandom_range(0, 99) < 30);
    s.wb_en     = ($urandom_range(0, 99) < 70);
    s.mem_read  = ($urandom_range(0, 99) < 30);
    s.mem_write = !s.mem_read && ($urandom_range(0, 99) < 20);
    s.stall     = ($urandom_range(0, 99) < 20);
    s.flush     = ($urandom_range(0, 99) < 8);
    s.mfe       = ($urandom_range(0, 99) < 50);
    s.mfd       = 5'($urandom_range(0, 3));
    s.mfdata    = $urandom;
    s.wfe       = ($urandom_range(0, 99) < 50);
    s.wfd       = 5'($urandom_range(0, 3));
    s.wfdata    = $urandom;
    return s;
  endfunction

  always @(negedge clk) begin
    if (sb_on && !rst) begin
      if (sb_q.size() == 0) begin
        check("sb_underflow", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check("load_use_stall", 32'(bus.load_use_stall), 32'(e.lus));
        check("ex_valid", 32'(bus.ex_valid), 32'(e.valid));
        check("ex_wb_en", 32'(bus.ex_wb_en), 32'(e.wb));
        check("ex_mem_read", 32'(bus.ex_mem_read), 32'(e.mr));
        check("ex_mem_write", 32'(bus.ex_mem_write), 32'(e.mw));
        if (e.valid) begin
          check("ex_pc", bus.ex_pc, e.pc);
          check("alu_dataa", bus.alu_dataa, e.a);
          check("alu_datab", bus.alu_datab, e.b);
          check("ex_store_data", bus.ex_store_data, e.store);
          check("alu_function", 32'(bus.alu_function), 32'(e.func));
          check("ex_dest", 32'(bus.ex_dest), 32'(e.dest));
        end
      end
    end
  end

  initial begin
    stim_t s;
    ex = '{default: '0};
    apply(idle());
    #1;
    check("rst_ex_valid", 32'(bus.ex_valid), 32'd0);
    check("rst_alu_function", 32'(bus.alu_function), 32'd0);
    check("rst_alu_dataa", bus.alu_dataa, 32'd0);
    check("rst_alu_datab", bus.alu_datab, 32'd0);
    check("rst_ex_pc", bus.ex_pc, 32'd0);
    check("rst_store", bus.ex_store_data, 32'd0);
    check("rst_lus", 32'(bus.load_use_stall), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    sb_on = 1;

    // ADD r3 = r1 + r2
    s = idle(); s.valid = 1; s.pc = 32'h40; s.rs = 1; s.rt = 2; s.dest = 3;
    s.rs_val = 5; s.rt_val = 7; s.wb_en = 1; s.func = 4'b0000;
    drive_cycle(s);
    drive_cycle(idle());

    // Reads r1 while EX/MEM and MEM/WB both write r1; then the r0 variant
    s = idle(); s.valid = 1; s.rs = 1; s.rt = 2; s.rs_val = 32'h99; s.dest = 5; s.func = 4'b0010;
    drive_cycle(s);
    s = idle(); s.mfe = 1; s.mfd = 1; s.mfdata = 32'h10; s.wfe = 1; s.wfd = 1; s.wfdata = 32'h20;
    drive_cycle(s);
    s = idle(); s.valid = 1; s.rs = 0; s.rt = 0; s.rs_val = 32'h77; s.dest = 5;
    drive_cycle(s);
    s = idle(); s.mfe = 1; s.mfd = 0; s.mfdata = 32'h10; s.wfe = 1; s.wfd = 0; s.wfdata = 32'h20;
    drive_cycle(s);

    // lw r4, then a consumer of r4
    s = idle(); s.valid = 1; s.rs = 5; s.dest = 4; s.wb_en = 1; s.mem_read = 1;
    drive_cycle(s);
    s = idle(); s.valid = 1; s.rs = 4; s.rt = 6; s.dest = 7; s.wb_en = 1; s.rs_val = 32'h1;
    drive_cycle(s);
    s.mfe = 1; s.mfd = 4; s.mfdata = 32'hD00D;
    drive_cycle(s);
    s = idle(); s.mfe = 1; s.mfd = 4; s.mfdata = 32'hDEAD;
    drive_cycle(s);

    // Held three cycles while MEM/WB retires r2
    s = idle(); s.valid = 1; s.rs = 3; s.rt = 2; s.rt_val = 32'h1111; s.dest = 8; s.wb_en = 1;
    drive_cycle(s);
    s = idle(); s.stall = 1; s.wfe = 1; s.wfd = 2; s.wfdata = 32'hABCD;
    drive_cycle(s);
    s = idle(); s.stall = 1;
    drive_cycle(s);
    drive_cycle(s);
    drive_cycle(idle());

    // flush + stall with sw in ID
    s = idle(); s.valid = 1; s.rs = 1; s.rt = 2; s.mem_write = 1; s.stall = 1; s.flush = 1;
    drive_cycle(s);
    drive_cycle(idle());

    // ORI with rt forwarded from EX/MEM
    s = idle(); s.valid = 1; s.rs = 1; s.rt = 3; s.dest = 3; s.use_imm = 1;
    s.imm = 32'hFFFF; s.func = 4'b0101; s.wb_en = 1;
    drive_cycle(s);
    s = idle(); s.mfe = 1; s.mfd = 3; s.mfdata = 32'h55;
    drive_cycle(s);

    for (int i = 0; i < 600; i++) drive_cycle(rand_stim());

    // Reset arriving while an instruction is held
    s = idle(); s.valid = 1; s.pc = 32'h100; s.rs = 1; s.rs_val = 32'h1234; s.dest = 2;
    drive_cycle(s);
    sb_on = 0;
    s = idle(); s.stall = 1;
    apply(s);
    #1;
    check("hold_ex_valid", 32'(bus.ex_valid), 32'(ex.valid));
    check("hold_ex_pc", bus.ex_pc, ex.pc);
    #1;
    rst = 1'b1;
    #1;
    check("async_rst_valid", 32'(bus.ex_valid), 32'd0);
    check("async_rst_pc", bus.ex_pc, 32'd0);
    check("async_rst_dataa", bus.alu_dataa, 32'd0);
    check("async_rst_func", 32'(bus.alu_function), 32'd0);
    @(posedge clk);
    #1;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
